drbg_sync_transmitter: RTL and testbench

Master-side sync-packet transmitter for the hash DRBG synchronisation link. Once per video frame it latches the master DRBG reseed counter and the V flag, and serialises them one bit per strobe slot (e.g. one VBI line) into the outgoing stream. It optionally appends a CRC. After each packet it issues a single `next_seed` pulse so the master DRBG advances in lock-step with what the slave-side synchroniser expects.

---
 rtl/drbg_sync_transmitter.sv | 148 ++++++++++++++
 tb/tb_drbg_sync_transmitter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drbg_sync_transmitter.sv
// Master-side DRBG sync-packet serialiser: PREAMBLE, sequence, V, optional CRC-8.
// Define DRBG_SYNC_TX_CRC_EN to append the CRC (49-bit packet, else 41 bits).
module drbg_sync_transmitter #(
  parameter logic [7:0] PREAMBLE = 8'hA5,
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_done,
  input  logic [31:0] sequence_internal,
  input  logic        V,
  input  logic        frame_start,
  input  logic        bit_strobe,
  output logic        tx_bit,
  output logic        tx_bit_valid,
  output logic        busy,
  output logic        next_seed,
  output logic        overrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] PKT_LAST = 6'd40;
  localparam logic [5:0] CRC_FROM = 6'd8;
`ifdef DRBG_SYNC_TX_CRC_EN
  localparam logic [5:0] LAST = 6'd48;
`else
  localparam logic [5:0] LAST = 6'd40;
`endif

  logic [1:0]  state_q, state_d;
  logic [40:0] pkt_q, pkt_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        tx_bit_q, tx_bit_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        next_seed_q, next_seed_d;
  logic        overrun_q, overrun_d;

`ifdef DRBG_SYNC_TX_CRC_EN
  logic [7:0]  crc_q, crc_d;
  logic        fb;
`else
  logic        unused_poly;
  assign unused_poly = ^CRC_POLY;
`endif

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    cnt_d       = cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_valid_d  = 1'b0;
    busy_d      = busy_q;
    next_seed_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef DRBG_SYNC_TX_CRC_EN
    crc_d       = crc_q;
    fb          = crc_q[7] ^ pkt_q[40];
`endif
    unique case (state_q)
      IDLE: begin
        // strobes here, including one coincident with the latch, are dropped
        if (frame_start && init_done) begin
          pkt_d   = {PREAMBLE, sequence_internal, V};
          cnt_d   = 6'd0;
          busy_d  = 1'b1;
          state_d = SEND;
`ifdef DRBG_SYNC_TX_CRC_EN
          crc_d   = 8'h00;
`endif
        end
      end
      SEND: begin
        overrun_d = frame_start;
        if (bit_strobe) begin
          tx_valid_d = 1'b1;
          cnt_d      = cnt_q + 6'd1;
`ifdef DRBG_SYNC_TX_CRC_EN
          if (cnt_q > PKT_LAST) begin
            tx_bit_d = crc_q[7];
            crc_d    = {crc_q[6:0], 1'b0};
          end else begin
            tx_bit_d = pkt_q[40];
            pkt_d    = {pkt_q[39:0], 1'b0};
            if (cnt_q >= CRC_FROM) begin
              crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
            end
          end
`else
          tx_bit_d = pkt_q[40];
          pkt_d    = {pkt_q[39:0], 1'b0};
`endif
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        overrun_d   = frame_start;
        next_seed_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pkt_q       <= '0;
      cnt_q       <= '0;
      tx_bit_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      next_seed_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef DRBG_SYNC_TX_CRC_EN
      crc_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      cnt_q       <= cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      next_seed_q <= next_seed_d;
      overrun_q   <= overrun_d;
`ifdef DRBG_SYNC_TX_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign tx_bit       = tx_bit_q;
  assign tx_bit_valid = tx_valid_q;
  assign busy         = busy_q;
  assign next_seed    = next_seed_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_drbg_sync_transmitter.sv
// Directed bench for drbg_sync_transmitter.
// Packet length follows DRBG_SYNC_TX_CRC_EN as in the design.
module tb_drbg_sync_transmitter;

`ifdef DRBG_SYNC_TX_CRC_EN
  localparam int N = 49;
`else
  localparam int N = 41;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done;
  logic [31:0] sequence_internal;
  logic        V;
  logic        frame_start;
  logic        bit_strobe;
  logic        tx_bit;
  logic        tx_bit_valid;
  logic        busy;
  logic        next_seed;
  logic        overrun;

  drbg_sync_transmitter dut (
    .clk               (clk),
    .reset             (reset),
    .init_done         (init_done),
    .sequence_internal (sequence_internal),
    .V                 (V),
    .frame_start       (frame_start),
    .bit_strobe        (bit_strobe),
    .tx_bit            (tx_bit),
    .tx_bit_valid      (tx_bit_valid),
    .busy              (busy),
    .next_seed         (next_seed),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int ns_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  int last_t = 0;
  int ns_t = 0;
  logic [63:0] rx_bits = '0;
  int rx0, ns0, ov0, busy0;

  always @(negedge clk) begin
    if (tx_bit_valid) begin
      rx_bits = {rx_bits[62:0], tx_bit};
      rx_cnt  = rx_cnt + 1;
      last_t  = cyc;
    end
    if (next_seed) begin
      ns_cnt = ns_cnt + 1;
      ns_t   = cyc;
    end
    if (overrun) ov_cnt = ov_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk = nchk + 1;
    if (got !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c,
                                          input logic b);
    logic f;
    f = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (f ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [63:0] exp_pkt(input logic [31:0] s,
                                          input logic v);
    logic [63:0] p;
`ifdef DRBG_SYNC_TX_CRC_EN
    logic [7:0] c;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) c = crc_step(c, s[i]);
    c = crc_step(c, v);
    p = {15'd0, 8'hA5, s, v, c};
`else
    p = {23'd0, 8'hA5, s, v};
`endif
    return p;
  endfunction

  task automatic snap();
    rx0   = rx_cnt;
    ns0   = ns_cnt;
    ov0   = ov_cnt;
    busy0 = busy_cnt;
  endtask

  task automatic start(input logic [31:0] s, input logic v,
                       input logic with_strobe);
    snap();
    sequence_internal = s;
    V           = v;
    frame_start = 1'b1;
    bit_strobe  = with_strobe;
    tick(1);
    frame_start = 1'b0;
    bit_strobe  = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
  endtask

  task automatic strobe(input int sp);
    bit_strobe = 1'b1;
    tick(1);
    bit_strobe  = 1'b0;
    frame_start = 1'b0;
    tick(sp - 1);
  endtask

  task automatic verify(input string tag, input logic [31:0] s,
                        input logic v);
    logic [63:0] mask;
    mask = (64'd1 << N) - 64'd1;
    chk({tag, "_nbits"}, 64'(rx_cnt - rx0), 64'(N));
    chk({tag, "_bits"}, rx_bits & mask, exp_pkt(s, v));
    chk({tag, "_nseed"}, 64'(ns_cnt - ns0), 64'd1);
    chk({tag, "_lat"}, 64'(ns_t - last_t), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    init_done = 1'b0;
    sequence_internal = '0;
    V = 1'b0;
    frame_start = 1'b0;
    bit_strobe = 1'b0;
    tick(3);
    reset = 1'b0;
    chk("reset_out", 64'({tx_bit, tx_bit_valid, busy, next_seed, overrun}),
        64'd0);
    init_done = 1'b1;

    // seq A, V=1, inputs scrambled mid-packet
    start(32'h0000000A, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      if (i == 10) begin
        sequence_internal = 32'hDEADBEEF;
        V = 1'b0;
      end
      strobe(3);
    end
    tick(2);
    verify("s1", 32'h0000000A, 1'b1);
`ifdef DRBG_SYNC_TX_CRC_EN
    chk("s1_crc", {56'd0, rx_bits[7:0]}, 64'h6B);
`endif

    // back-to-back strobes, V=0
    start(32'h0000000A, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) strobe(1);
    tick(3);
    verify("s2", 32'h0000000A, 1'b0);
`ifdef DRBG_SYNC_TX_CRC_EN
    chk("s2_crc", {56'd0, rx_bits[7:0]}, 64'h6C);
`endif

    // overrun at strobe 20, init_done dropped mid-packet
    start(32'h12345678, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      if (i == 20) begin
        frame_start = 1'b1;
        sequence_internal = 32'hCAFEF00D;
      end
      if (i == 30) init_done = 1'b0;
      strobe(2);
    end
    tick(4);
    for (int i = 0; i < 5; i++) strobe(2);
    verify("s3", 32'h12345678, 1'b0);
    chk("s3_ovr", 64'(ov_cnt - ov0), 64'd1);

    // init_done low: everything ignored
    init_done = 1'b0;
    snap();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    for (int i = 0; i < 10; i++) strobe(2);
    tick(3);
    chk("s4_nbits", 64'(rx_cnt - rx0), 64'd0);
    chk("s4_nseed", 64'(ns_cnt - ns0), 64'd0);
    chk("s4_busy", 64'(busy_cnt - busy0), 64'd0);
    chk("s4_ovr", 64'(ov_cnt - ov0), 64'd0);
    init_done = 1'b1;
    start(32'h80000001, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) strobe(2);
    tick(3);
    verify("s4", 32'h80000001, 1'b1);

    // reset mid-packet, coincident with a strobe
    start(32'hFFFFFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) strobe(2);
    chk("s5_hold", 64'(tx_bit), 64'd1);
    reset = 1'b1;
    bit_strobe = 1'b1;
    tick(1);
    reset = 1'b0;
    bit_strobe = 1'b0;
    chk("s5_rst_out",
        64'({tx_bit, tx_bit_valid, busy, next_seed, overrun}), 64'd0);
    tick(5);
    chk("s5_nseed", 64'(ns_cnt - ns0), 64'd0);
    start(32'h0F0F1234, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) strobe(3);
    tick(2);
    verify("s5", 32'h0F0F1234, 1'b1);

    // all-ones sequence
    start(32'hFFFFFFFF, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) strobe(2);
    tick(3);
    verify("s6", 32'hFFFFFFFF, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
